// File: rtl/traffic_pkg.sv
// Shared types and constants for the highway / country-road phase scheduler.
package traffic_pkg;

    localparam int TIME_W = 7;

    typedef enum logic [2:0] {
        HW_GRN = 3'd0,
        HW_YEL = 3'd1,
        CLR1   = 3'd2,
        CR_GRN = 3'd3,
        CR_YEL = 3'd4,
        CLR2   = 3'd5
    } state_t;

    // Lamp encodings {red, yellow, green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// Loadable phase down-counter. Decrements once per tick, parks at zero,
// flags the last tick of a phase (count == 1).
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [TIME_W-1:0] RST_VAL = '0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              tick,
    output logic [TIME_W-1:0] count,
    output logic              expired,
    output logic              at_zero
);

    // Load has priority over counting; zero is a hold state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - TIME_W'(1);
        end
    end

    assign expired = (count == TIME_W'(1));
    assign at_zero = (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer: highway green by default, country road
// served on sensor or pedestrian demand, all-red clearance between roads.
//
//  state  | meaning
//  -------+---------------------------------------------------------
//  HW_GRN | highway green; min time, then hold at 0 until demand
//  HW_YEL | highway yellow
//  CLR1   | all-red clearance before country road
//  CR_GRN | country-road green; walk latched at entry; max or gap-out
//  CR_YEL | country-road yellow
//  CLR2   | all-red clearance before highway
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int HW_MIN_T = 8,
    parameter int HW_YEL_T = 3,
    parameter int CLR_T    = 1,
    parameter int CR_MAX_T = 10,
    parameter int CR_MIN_T = 3,
    parameter int CR_YEL_T = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              sensor,
    input  logic              ped_req,
    output logic [2:0]        hw_led,
    output logic [2:0]        cr_led,
    output logic              walk,
    output logic [TIME_W-1:0] phase_time,
    output logic [2:0]        phase
);

    localparam logic [TIME_W-1:0] HW_MIN_V = TIME_W'(HW_MIN_T);
    localparam logic [TIME_W-1:0] HW_YEL_V = TIME_W'(HW_YEL_T);
    localparam logic [TIME_W-1:0] CLR_V    = TIME_W'(CLR_T);
    localparam logic [TIME_W-1:0] CR_MAX_V = TIME_W'(CR_MAX_T);
    localparam logic [TIME_W-1:0] CR_YEL_V = TIME_W'(CR_YEL_T);
    // Gap-out is allowed once the counter, including the current tick, shows
    // at least CR_MIN_T elapsed ticks: CR_MAX_T - count + 1 >= CR_MIN_T.
    localparam logic [TIME_W-1:0] GAP_MAX  = TIME_W'(CR_MAX_T - CR_MIN_T + 1);

    state_t            state;
    state_t            state_nxt;
    logic              sync1;
    logic              sens_s;
    logic              ped_pending;
    logic              demand;
    logic              illegal;
    logic              enter_cr;
    logic              tmr_load;
    logic [TIME_W-1:0] tmr_val;
    logic [TIME_W-1:0] count;
    logic              expired;
    logic              at_zero;

    phase_timer #(
        .RST_VAL (HW_MIN_V)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .count    (count),
        .expired  (expired),
        .at_zero  (at_zero)
    );

    // Two-flop synchronizer for the asynchronous vehicle sensor.
    always_ff @(posedge clk) begin
        if (rst || illegal) begin
            sync1  <= 1'b0;
            sens_s <= 1'b0;
        end else begin
            sync1  <= sensor;
            sens_s <= sync1;
        end
    end

    assign demand = sens_s | ped_pending;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HW_GRN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and timer reload; every transition loads the next duration.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = HW_MIN_V;
        illegal   = 1'b0;
        case (state)
            HW_GRN: begin
                if (tick && (expired || at_zero) && demand) begin
                    state_nxt = HW_YEL;
                    tmr_load  = 1'b1;
                    tmr_val   = HW_YEL_V;
                end
            end
            HW_YEL: begin
                if (tick && expired) begin
                    state_nxt = CLR1;
                    tmr_load  = 1'b1;
                    tmr_val   = CLR_V;
                end
            end
            CLR1: begin
                if (tick && expired) begin
                    state_nxt = CR_GRN;
                    tmr_load  = 1'b1;
                    tmr_val   = CR_MAX_V;
                end
            end
            CR_GRN: begin
                if (tick && (expired || (!walk && !sens_s && (count <= GAP_MAX)))) begin
                    state_nxt = CR_YEL;
                    tmr_load  = 1'b1;
                    tmr_val   = CR_YEL_V;
                end
            end
            CR_YEL: begin
                if (tick && expired) begin
                    state_nxt = CLR2;
                    tmr_load  = 1'b1;
                    tmr_val   = CLR_V;
                end
            end
            CLR2: begin
                if (tick && expired) begin
                    state_nxt = HW_GRN;
                    tmr_load  = 1'b1;
                    tmr_val   = HW_MIN_V;
                end
            end
            default: begin
                state_nxt = HW_GRN;
                tmr_load  = 1'b1;
                tmr_val   = HW_MIN_V;
                illegal   = 1'b1;
            end
        endcase
    end

    assign enter_cr = (state == CLR1) && (state_nxt == CR_GRN);

    // Pedestrian latch and walk; a request on the entry edge is served now.
    always_ff @(posedge clk) begin
        if (rst || illegal) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
        end else begin
            if (enter_cr) begin
                ped_pending <= 1'b0;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end
            if (enter_cr) begin
                walk <= ped_pending | ped_req;
            end else if (state_nxt != CR_GRN) begin
                walk <= 1'b0;
            end
        end
    end

    // Lamp decode from the current state.
    always_comb begin
        hw_led = RED;
        cr_led = RED;
        case (state)
            HW_GRN:  hw_led = GRN;
            HW_YEL:  hw_led = YEL;
            CR_GRN:  cr_led = GRN;
            CR_YEL:  cr_led = YEL;
            default: ;
        endcase
    end

    assign phase      = state;
    assign phase_time = count;

    // At least one road must always show red.
    a_one_red: assert property (@(posedge clk) disable iff (rst) (hw_led[2] | cr_led[2]));

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Tick-level bench for traffic_phase_scheduler: per-tick expected records
// are built from phase durations, pushed to a scoreboard and compared.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] P_HWG = 3'd0;
    localparam logic [2:0] P_HWY = 3'd1;
    localparam logic [2:0] P_CL1 = 3'd2;
    localparam logic [2:0] P_CRG = 3'd3;
    localparam logic [2:0] P_CRY = 3'd4;
    localparam logic [2:0] P_CL2 = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       sensor;
    logic       ped_req;
    logic [2:0] hw_led;
    logic [2:0] cr_led;
    logic       walk;
    logic [6:0] phase_time;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       sens;
        logic [1:0] ped;    // 0 none, 1 pulse at period start, 2 pulse on the tick cycle
        logic [2:0] phase;
        logic [6:0] ptime;
        logic       walk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    traffic_phase_scheduler #(
        .HW_MIN_T (4),
        .HW_YEL_T (2),
        .CLR_T    (1),
        .CR_MAX_T (6),
        .CR_MIN_T (2),
        .CR_YEL_T (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .sensor     (sensor),
        .ped_req    (ped_req),
        .hw_led     (hw_led),
        .cr_led     (cr_led),
        .walk       (walk),
        .phase_time (phase_time),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps(input logic [2:0] p);
        case (p)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic compare_out(input string tag, input int idx);
        vec_t e;
        logic [5:0] l;
        if (sb.size() == 0) begin
            check($sformatf("%s[%0d].scoreboard_empty", tag, idx), 0, 1);
            return;
        end
        e = sb.pop_front();
        l = lamps(e.phase);
        check($sformatf("%s[%0d].phase", tag, idx), int'(phase), int'(e.phase));
        check($sformatf("%s[%0d].phase_time", tag, idx), int'(phase_time), int'(e.ptime));
        check($sformatf("%s[%0d].walk", tag, idx), int'(walk), int'(e.walk));
        check($sformatf("%s[%0d].hw_led", tag, idx), int'(hw_led), int'(l[5:3]));
        check($sformatf("%s[%0d].cr_led", tag, idx), int'(cr_led), int'(l[2:0]));
        check($sformatf("%s[%0d].one_red", tag, idx), int'(hw_led[2] | cr_led[2]), 1);
    endtask

    // One tick period: 4 clocks, tick high on the last one.
    task automatic run_period(input vec_t v, input string tag, input int idx);
        sensor = v.sens;
        if (v.ped == 2'd1) ped_req = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        ped_req = 1'b0;
        compare_out(tag, idx);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick = 1'b1;
        if (v.ped == 2'd2) ped_req = 1'b1;
        @(posedge clk); #1;
        tick    = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic add(input logic [2:0] ph, input int t0, input int n,
                       input logic w, input logic s, input logic [1:0] ped0);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.sens  = s;
            v.ped   = (i == 0) ? ped0 : 2'd0;
            v.phase = ph;
            v.ptime = (t0 - i > 0) ? 7'(t0 - i) : 7'd0;
            v.walk  = w;
            tbl.push_back(v);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) run_period(tbl[i], tag, i);
        tbl.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        tick    = 1'b0;
        sensor  = 1'b0;
        ped_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        tick    = 1'b0;
        sensor  = 1'b0;
        ped_req = 1'b0;

        // 1: idle highway, green holds indefinitely
        do_reset();
        check("reset.phase", int'(phase), 0);
        check("reset.phase_time", int'(phase_time), 4);
        check("reset.hw_led", int'(hw_led), 1);
        check("reset.cr_led", int'(cr_led), 4);
        check("reset.walk", int'(walk), 0);
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 0, 26, 1'b0, 1'b0, 2'd0);
        run_table("idle");

        // 2: sensor held, full cycle at maximum country-road green
        do_reset();
        add(P_HWG, 4, 4, 1'b0, 1'b1, 2'd0);
        add(P_HWY, 2, 2, 1'b0, 1'b1, 2'd0);
        add(P_CL1, 1, 1, 1'b0, 1'b1, 2'd0);
        add(P_CRG, 6, 6, 1'b0, 1'b1, 2'd0);
        add(P_CRY, 2, 2, 1'b0, 1'b1, 2'd0);
        add(P_CL2, 1, 1, 1'b0, 1'b1, 2'd0);
        add(P_HWG, 4, 1, 1'b0, 1'b1, 2'd0);
        run_table("sensor_held");

        // 3: sensor drops at country-road entry, gap-out after CR_MIN_T
        do_reset();
        add(P_HWG, 4, 4, 1'b0, 1'b1, 2'd0);
        add(P_HWY, 2, 2, 1'b0, 1'b1, 2'd0);
        add(P_CL1, 1, 1, 1'b0, 1'b1, 2'd0);
        add(P_CRG, 6, 2, 1'b0, 1'b0, 2'd0);
        add(P_CRY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL2, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 0, 3, 1'b0, 1'b0, 2'd0);
        run_table("gap_out");

        // 4: pedestrian request only, walk for full green, then idle
        do_reset();
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd1);
        add(P_HWY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL1, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_CRG, 6, 6, 1'b1, 1'b0, 2'd0);
        add(P_CRY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL2, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 0, 3, 1'b0, 1'b0, 2'd0);
        run_table("ped_only");

        // 5: request on the CLR1 -> CR_GRN edge is served by this green
        do_reset();
        add(P_HWG, 4, 4, 1'b0, 1'b1, 2'd0);
        add(P_HWY, 2, 2, 1'b0, 1'b1, 2'd0);
        add(P_CL1, 1, 1, 1'b0, 1'b0, 2'd2);
        add(P_CRG, 6, 6, 1'b1, 1'b0, 2'd0);
        add(P_CRY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL2, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 0, 3, 1'b0, 1'b0, 2'd0);
        run_table("ped_on_entry");

        // 7: request during a no-walk green is served on the next cycle
        do_reset();
        add(P_HWG, 4, 4, 1'b0, 1'b1, 2'd0);
        add(P_HWY, 2, 2, 1'b0, 1'b1, 2'd0);
        add(P_CL1, 1, 1, 1'b0, 1'b1, 2'd0);
        add(P_CRG, 6, 2, 1'b0, 1'b0, 2'd1);
        add(P_CRY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL2, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd0);
        add(P_HWY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL1, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_CRG, 6, 6, 1'b1, 1'b0, 2'd0);
        add(P_CRY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL2, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 0, 2, 1'b0, 1'b0, 2'd0);
        run_table("ped_in_green");

        // 6: reset in the middle of a walk green
        do_reset();
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd1);
        add(P_HWY, 2, 2, 1'b0, 1'b0, 2'd0);
        add(P_CL1, 1, 1, 1'b0, 1'b0, 2'd0);
        add(P_CRG, 6, 3, 1'b1, 1'b0, 2'd0);
        run_table("pre_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset.phase", int'(phase), 0);
        check("midreset.phase_time", int'(phase_time), 4);
        check("midreset.hw_led", int'(hw_led), 1);
        check("midreset.cr_led", int'(cr_led), 4);
        check("midreset.walk", int'(walk), 0);
        add(P_HWG, 4, 4, 1'b0, 1'b0, 2'd0);
        add(P_HWG, 0, 2, 1'b0, 1'b0, 2'd0);
        run_table("post_reset");

        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
